input_ram_reader: RTL and testbench
===================================

Name: input_ram_reader

Overview:
- Read-side sequencer for the 1024×12 dual-port sample buffer. Once a frame has been written through port A, it drives the buffer's port B address and absorbs the buffer's one-cycle registered-address read latency.
- Streams the frame out in address order on a valid/ready interface, with last-sample marking and a done pulse, into the estimator datapath.
- Sustains one sample per clock under continuous ready and loses no data under backpressure.

Parameters:
- Addr_Width, 10, buffer address width; maximum frame is 2**Addr_Width samples
- Data_Width, 12, sample width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to read one frame; honoured only in IDLE
- len_m1  in  Addr_Width  frame length minus one; sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final sample handshake
- ram_addr_b  out  Addr_Width  read address to buffer port B
- ram_dout_b  in  Data_Width  buffer port B data; valid the cycle after the address is presented
- m_data  out  Data_Width  output sample
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_last  out  1  marks the sample read from address len_m1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - state = IDLE; busy, done, m_valid and m_last are 0.
  - ram_addr_b = 0; issue and output counters = 0; FIFO empty; in-flight flag cleared.
  - Reset mid-frame discards all in-flight and buffered data. No done is produced for the aborted frame.
- States: IDLE, READ, DRAIN.
  - IDLE -> READ on start. Latch len_m1; issue address = 0.
  - READ: may issue an address in any cycle that satisfies the issue rule. When address len_m1 is issued, go to DRAIN.
  - DRAIN: no issues. When the handshake (m_valid & m_ready) with m_last occurs, go to IDLE and pulse done in the next cycle.
  - start outside IDLE is ignored.
  - start in the same cycle as the done pulse is accepted, because the state is already IDLE.
- Read timing:
  - An issue in cycle t presents ram_addr_b in cycle t.
  - ram_dout_b is pushed into a 2-entry output FIFO at the end of cycle t+1.
  - ram_addr_b holds its last value when not issuing.
- Issue rule: issue when (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready in the current cycle. This guarantees no FIFO overflow and full throughput.
- Output:
  - m_data and m_valid come from the FIFO head.
  - m_data, m_valid and m_last stay stable while m_valid & !m_ready.
  - m_last is carried per entry; it is set for the entry read from address len_m1.
- Latency: start sampled in cycle 0 gives the first m_valid in cycle 3 (address issued in cycle 1, pushed at the end of cycle 2).
- Frame length and wrap:
  - len_m1 = 0 produces a single-sample frame with m_last on that sample.
  - len_m1 = 2**Addr_Width−1 reads the full buffer. The address counter must not wrap before the final issue.
- Width rules:
  - Counters are Addr_Width bits.
  - The comparison against len_m1 is exact equality. No extra MSB is needed because the last index is len_m1.
- Duration: with m_ready held high, exactly len_m1+1 consecutive valid cycles occur. done follows one cycle after the last handshake.

Decomposition:
- Package input_ram_pkg holds:
  - the state enum (IDLE, READ, DRAIN)
  - default ADDR_WIDTH = 10 and DATA_WIDTH = 12
  - FIFO depth constant = 2
- Sub-module rd_skid_fifo: a 2-entry FIFO of {last, data}.
  - Inputs: push, push data, pop.
  - Outputs: head, valid, count.
  - Supports push and pop in the same cycle.

Test Plan:
- Full frame, m_ready = 1: buffer preloaded with data = address; start with len_m1 = 1023.
  - First m_valid 3 cycles after start.
  - 1024 consecutive samples 0x000..0x3FF.
  - m_last on 0x3FF; done one cycle later; busy falls with done.
- Backpressure: len_m1 = 15, m_ready toggled 1,0,0,1 repeating.
  - 16 samples in order, none lost or duplicated.
  - m_data held stable while stalled; ram_addr_b never more than 2 ahead of accepted samples.
- Single sample: len_m1 = 0, buffer[0] = 0xABC.
  - Exactly one beat 0xABC with m_last = 1, then done.
- Start while busy: a second start mid-frame is ignored. A start in the done cycle begins a new frame with the first m_valid 3 cycles later.
- Reset mid-frame: assert rst after 5 samples of a 64-sample frame.
  - Next cycle: m_valid = 0, busy = 0, no done.
  - A following start reads from address 0.
- m_ready held 0 for 20 cycles after start (len_m1 = 7):
  - At most 2 addresses issued.
  - On release, samples 0..7 are delivered in order.

Source files
------------

// File: rtl/input_ram_pkg.sv
// Shared types and defaults for the sample-buffer read sequencer.
package input_ram_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the buffer read latency.
// It accepts a push and a pop in the same cycle, including when it is full.
module rd_skid_fifo
  import input_ram_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [FIFO_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

  // Storage, pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/input_ram_reader.sv
// Reads one frame from port B of the sample buffer in address order and
// streams it on a valid/ready interface with last marking and a done pulse.
module input_ram_reader
  import input_ram_pkg::*;
#(
  parameter int unsigned Addr_Width = ADDR_WIDTH,
  parameter int unsigned Data_Width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Addr_Width-1:0] len_m1,
  output logic                  busy,
  output logic                  done,
  output logic [Addr_Width-1:0] ram_addr_b,
  input  logic [Data_Width-1:0] ram_dout_b,
  output logic [Data_Width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] len_q, len_d;
  logic [Addr_Width-1:0] issue_cnt_q, issue_cnt_d;
  logic [Addr_Width-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic [Data_Width:0]   fifo_head;
  logic                  fifo_valid;

  assign pop       = fifo_valid & m_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      len_q           <= '0;
      issue_cnt_q     <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issue_cnt_q     <= issue_cnt_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Next-state, issue decision and done generation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    issue       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d       = len_m1;
          issue_cnt_d = '0;
          state_d     = StRead;
        end
      end
      StRead: begin
        // occupancy - pop < 2, rearranged to stay unsigned.
        issue = (occupancy < (3'd2 + {2'b00, pop}));
        if (issue) begin
          addr_d      = issue_cnt_q;
          issue_cnt_d = issue_cnt_q + Addr_Width'(1);
          if (issue_cnt_q == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && fifo_head[Data_Width]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    inflight_d      = issue;
    inflight_last_d = issue && (issue_cnt_q == len_q);
  end

  // The issued address goes out in its own cycle; otherwise hold the last one.
  assign ram_addr_b = issue ? issue_cnt_q : addr_q;

  rd_skid_fifo #(
    .Width(Data_Width + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({inflight_last_q, ram_dout_b}),
    .pop      (pop),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_head[Data_Width-1:0];
  assign m_last  = fifo_valid & fifo_head[Data_Width];

endmodule

// File: tb/tb_input_ram_reader.sv
// Directed bench for input_ram_reader with a registered-read buffer model.
module tb_input_ram_reader;

  localparam int AW = 10;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] len_m1;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] mem [1024];
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  // Buffer port B: address registered on the edge, data valid the next cycle.
  always @(posedge clk) ram_dout_b <= mem[ram_addr_b];

  input_ram_reader #(
    .Addr_Width(AW),
    .Data_Width(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_m1    (len_m1),
    .busy      (busy),
    .done      (done),
    .ram_addr_b(ram_addr_b),
    .ram_dout_b(ram_dout_b),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; len_m1 = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({busy, done, m_valid, m_last} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, m_valid, m_last});
    else pass_cnt++;
    total_cnt++;
    if (ram_addr_b !== 10'd0) $display("FAIL reset_addr: got %0d expected 0", ram_addr_b);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_frame;
    @(negedge clk); m_ready = 1'b1; start = 1'b1; len_m1 = 10'd1023;
    @(negedge clk); start = 1'b0; #1;
    total_cnt++;
    if ({busy, m_valid} !== 2'b10) $display("FAIL full_c1: got %b expected 10", {busy, m_valid});
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL full_c2_valid: got %b expected 0", m_valid);
    else pass_cnt++;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 1023), 12'(i)})
        $display("FAIL full_beat%0d: got v%b l%b %h expected v1 l%b %h",
                 i, m_valid, m_last, m_data, (i == 1023), 12'(i));
      else pass_cnt++;
      if (i == 1023) begin
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL full_busy_last: got %b expected 1", busy);
        else pass_cnt++;
      end
    end
    @(negedge clk); #1;
    total_cnt++;
    if ({done, busy, m_valid} !== 3'b100)
      $display("FAIL full_done: got %b expected 100", {done, busy, m_valid});
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL full_done_pulse: got %b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int          idx = 0;
    int          cyc = 0;
    int          bound;
    logic        stalled = 1'b0;
    logic [12:0] held = '0;
    @(negedge clk); m_ready = 1'b1; start = 1'b1; len_m1 = 10'd15;
    while (idx < 16 && cyc < 200) begin
      @(negedge clk);
      start   = 1'b0;
      m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      if (stalled) begin
        total_cnt++;
        if ({m_valid, m_last, m_data} !== {1'b1, held})
          $display("FAIL bp_hold: got v%b %h expected v1 %h", m_valid, {m_last, m_data}, held);
        else pass_cnt++;
      end
      bound = idx + ((m_valid && m_ready) ? 1 : 0) + 1;
      total_cnt++;
      if (int'(ram_addr_b) > bound)
        $display("FAIL bp_addr_ahead: got %0d expected <= %0d", ram_addr_b, bound);
      else pass_cnt++;
      if (m_valid && m_ready) begin
        total_cnt++;
        if ({m_last, m_data} !== {(idx == 15), 12'(idx)})
          $display("FAIL bp_beat%0d: got l%b %h expected l%b %h",
                   idx, m_last, m_data, (idx == 15), 12'(idx));
        else pass_cnt++;
        idx++;
      end
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
      cyc++;
    end
    total_cnt++;
    if (idx !== 16) $display("FAIL bp_count: got %0d expected 16", idx);
    else pass_cnt++;
    @(negedge clk); m_ready = 1'b1; #1;
    total_cnt++;
    if ({done, m_valid} !== 2'b10) $display("FAIL bp_done: got %b expected 10", {done, m_valid});
    else pass_cnt++;
  endtask

  task automatic test_single;
    mem[0] = 12'hABC;
    @(negedge clk); m_ready = 1'b1; start = 1'b1; len_m1 = 10'd0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL single_early: got %b expected 0", m_valid);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({m_valid, m_last, m_data} !== {2'b11, 12'hABC})
      $display("FAIL single_beat: got v%b l%b %h expected v1 l1 abc", m_valid, m_last, m_data);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({done, m_valid} !== 2'b10) $display("FAIL single_done: got %b expected 10", {done, m_valid});
    else pass_cnt++;
    mem[0] = 12'h000;
  endtask

  task automatic test_start_busy;
    @(negedge clk); m_ready = 1'b1; start = 1'b1; len_m1 = 10'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; len_m1 = 10'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b0; #1;
      total_cnt++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 3), 12'(i)})
        $display("FAIL busy_beat%0d: got v%b l%b %h expected v1 l%b %h",
                 i, m_valid, m_last, m_data, (i == 3), 12'(i));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL busy_done: got %b expected 1", done);
    else pass_cnt++;
    start = 1'b1; len_m1 = 10'd2;
    @(negedge clk); start = 1'b0; #1;
    total_cnt++;
    if ({busy, m_valid} !== 2'b10) $display("FAIL restart_c1: got %b expected 10", {busy, m_valid});
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (m_valid !== 1'b0) $display("FAIL restart_c2: got %b expected 0", m_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 2), 12'(i)})
        $display("FAIL restart_beat%0d: got v%b l%b %h expected v1 l%b %h",
                 i, m_valid, m_last, m_data, (i == 2), 12'(i));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++;
    if ({done, m_valid} !== 2'b10) $display("FAIL restart_done: got %b expected 10", {done, m_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); m_ready = 1'b1; start = 1'b1; len_m1 = 10'd63;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({m_valid, m_data} !== {1'b1, 12'(i)})
        $display("FAIL rmid_beat%0d: got v%b %h expected v1 %h", i, m_valid, m_data, 12'(i));
      else pass_cnt++;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++;
    if ({m_valid, busy, done} !== 3'b000)
      $display("FAIL rmid_after: got %b expected 000", {m_valid, busy, done});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({done, m_valid} !== 2'b00) $display("FAIL rmid_quiet%0d: got %b expected 00", i, {done, m_valid});
      else pass_cnt++;
    end
    @(negedge clk); start = 1'b1; len_m1 = 10'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total_cnt++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 3), 12'(i)})
        $display("FAIL rmid_new_beat%0d: got v%b l%b %h expected v1 l%b %h",
                 i, m_valid, m_last, m_data, (i == 3), 12'(i));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1) $display("FAIL rmid_new_done: got %b expected 1", done);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    int max_addr = 0;
    @(negedge clk); m_ready = 1'b0; start = 1'b1; len_m1 = 10'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (int'(ram_addr_b) > max_addr) max_addr = int'(ram_addr_b);
    end
    total_cnt++;
    if (max_addr > 1) $display("FAIL stall_issue: got max addr %0d expected <= 1", max_addr);
    else pass_cnt++;
    total_cnt++;
    if ({busy, m_valid, m_data} !== {2'b11, 12'h000})
      $display("FAIL stall_head: got b%b v%b %h expected b1 v1 000", busy, m_valid, m_data);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); m_ready = 1'b1; #1;
      total_cnt++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 7), 12'(i)})
        $display("FAIL stall_beat%0d: got v%b l%b %h expected v1 l%b %h",
                 i, m_valid, m_last, m_data, (i == 7), 12'(i));
      else pass_cnt++;
    end
    @(negedge clk); #1;
    total_cnt++;
    if ({done, m_valid} !== 2'b10) $display("FAIL stall_done: got %b expected 10", {done, m_valid});
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 12'(i);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_single();
    test_start_busy();
    test_reset_mid();
    test_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
